// File: rtl/reg_bank_wr_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter.
// Optional feature macro: REG0_PROTECT_EN (register 0 read-only).
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        HOLD  = 2'b10
    } arb_state_e;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned DW_DEF   = 8;
    localparam int unsigned NREG_DEF = 8;
    localparam int unsigned AW_DEF   = 3;

    // Widest bank supported; instances slice the low NREG bits.
    localparam int unsigned MAX_NREG = 256;
    localparam logic [MAX_NREG-1:0] WEN_IDLE = '1;

    // True when a granted write to this address must not reach the bank.
    function automatic logic addr_blocked(input int unsigned addr, input int unsigned nreg);
`ifdef REG0_PROTECT_EN
        return (addr >= nreg) || (addr == 0);
`else
        return (addr >= nreg);
`endif
    endfunction

endpackage

// File: rtl/reg_bank_wr_arbiter_if.sv
// Requester/bank bus of the write arbiter: packed per-requester request,
// address and data in; grant, register enables and shared write data out.
interface reg_bank_wr_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = AW_DEF
);
    logic [NREQ-1:0]    req_i;
    logic [NREQ*AW-1:0] addr_i;
    logic [NREQ*DW-1:0] data_i;
    logic [NREQ-1:0]    gnt_o;
    logic [NREG-1:0]    wen_o;
    logic [DW-1:0]      wdata_o;
    logic               busy_o;
    logic               err_o;

    modport master (
        output req_i, addr_i, data_i,
        input  gnt_o, wen_o, wdata_o, busy_o, err_o
    );

    modport slave (
        input  req_i, addr_i, data_i,
        output gnt_o, wen_o, wdata_o, busy_o, err_o
    );
endinterface

// File: rtl/reg_bank_wr_arbiter_rr_prio_enc.sv
// Rotating priority encoder: first asserted request at or after ptr_i,
// wrapping from NREQ-1 back to 0.
module rr_prio_enc #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
)(
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);
    int unsigned pos;
    logic        found;

    // Scan requests starting from the pointer; keep the first hit.
    always_comb begin
        idx_o = '0;
        pos   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pos = (32'(ptr_i) + i) % NREQ;
            if (!found && req_i[pos]) begin
                found = 1'b1;
                idx_o = IW'(pos);
            end
        end
        valid_o = found;
    end
endmodule

// File: rtl/reg_bank_wr_arbiter.sv
// Round-robin write arbiter/sequencer for a dffe-style register bank.
// IDLE -> WRITE -> HOLD -> IDLE; one active-low enable per granted write.
// Optional feature macro: REG0_PROTECT_EN (writes to register 0 suppressed).
module reg_bank_wr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = AW_DEF
)(
    input  logic                 clk_i,
    input  logic                 clrn_i,
    reg_bank_wr_arbiter_if.slave wr_bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREG-1:0] WEN_ALL = WEN_IDLE[NREG-1:0];

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREG-1:0] wen_q, wen_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;

    logic [IW-1:0]   enc_idx;
    logic            enc_valid;
    logic [AW-1:0]   addr_sel;

    rr_prio_enc #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_enc (
        .req_i   (wr_bus.req_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    // Address presented by the requester the encoder currently selects.
    always_comb begin
        addr_sel = wr_bus.addr_i[enc_idx*AW +: AW];
    end

    // Next state and next output values. Outputs are registered, so the
    // write-cycle values are computed while still in IDLE; that is what
    // latches the winner's address/data at the sample edge.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        gnt_d    = '0;
        wen_d    = WEN_ALL;
        wdata_d  = wdata_q;
        busy_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    state_d        = WRITE;
                    win_d          = enc_idx;
                    gnt_d[enc_idx] = 1'b1;
                    wdata_d        = wr_bus.data_i[enc_idx*DW +: DW];
                    busy_d         = 1'b1;
                    if (addr_blocked(32'(addr_sel), NREG)) begin
                        err_d = 1'b1;
                    end else begin
                        wen_d[addr_sel] = 1'b0;
                    end
                end
            end
            WRITE: begin
                state_d  = HOLD;
                busy_d   = 1'b1;
                rr_ptr_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and output registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge clrn_i) begin
        if (!clrn_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            wen_q    <= WEN_ALL;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign wr_bus.gnt_o   = gnt_q;
    assign wr_bus.wen_o   = wen_q;
    assign wr_bus.wdata_o = wdata_q;
    assign wr_bus.busy_o  = busy_q;
    assign wr_bus.err_o   = err_q;
endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// Directed bench for reg_bank_wr_arbiter: one 8-register instance and one
// 6-register instance for the out-of-range case.
module tb_reg_bank_wr_arbiter;
    import reg_arb_pkg::*;

    logic clk = 1'b0;
    logic clrn;
    int   total = 0;
    int   bad   = 0;
    int   cyc;

    always #5 clk = ~clk;

    reg_bank_wr_arbiter_if #(.NREQ(4), .DW(8), .NREG(8), .AW(3)) bus8 ();
    reg_bank_wr_arbiter_if #(.NREQ(4), .DW(8), .NREG(6), .AW(3)) bus6 ();

    reg_bank_wr_arbiter #(.NREQ(4), .DW(8), .NREG(8), .AW(3)) dut (
        .clk_i  (clk),
        .clrn_i (clrn),
        .wr_bus (bus8.slave)
    );

    reg_bank_wr_arbiter #(.NREQ(4), .DW(8), .NREG(6), .AW(3)) dut6 (
        .clk_i  (clk),
        .clrn_i (clrn),
        .wr_bus (bus6.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic r, input logic [2:0] a, input logic [7:0] d);
        bus8.req_i[k]         = r;
        bus8.addr_i[k*3 +: 3] = a;
        bus8.data_i[k*8 +: 8] = d;
    endtask

    // Bounded wait for any grant on the 8-register instance.
    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus8.gnt_o == '0 && n < 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn        = 1'b0;
        bus8.req_i  = '0;
        bus8.addr_i = '0;
        bus8.data_i = '0;
        bus6.req_i  = '0;
        bus6.addr_i = '0;
        bus6.data_i = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_wen",   bus8.wen_o,   32'hFF);
        chk("rst_gnt",   bus8.gnt_o,   32'h0);
        chk("rst_wdata", bus8.wdata_o, 32'h0);
        chk("rst_busy",  bus8.busy_o,  32'h0);
        chk("rst_err",   bus8.err_o,   32'h0);
        chk("rst_wen6",  bus6.wen_o,   32'h3F);
        clrn = 1'b1;
        @(negedge clk);
        chk("idle_gnt", bus8.gnt_o, 32'h0);

        // Single write: requester 2, addr 5, data A5
        set_req(2, 1'b1, 3'd5, 8'hA5);
        @(negedge clk);
        chk("single_wen",   bus8.wen_o,   32'hDF);
        chk("single_wdata", bus8.wdata_o, 32'hA5);
        chk("single_gnt",   bus8.gnt_o,   32'h4);
        chk("single_busy",  bus8.busy_o,  32'h1);
        chk("single_err",   bus8.err_o,   32'h0);
        set_req(2, 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        chk("hold_wen",   bus8.wen_o,   32'hFF);
        chk("hold_gnt",   bus8.gnt_o,   32'h0);
        chk("hold_busy",  bus8.busy_o,  32'h1);
        chk("hold_wdata", bus8.wdata_o, 32'hA5);
        @(negedge clk);
        chk("idle_busy",  bus8.busy_o,  32'h0);
        chk("idle_wdata", bus8.wdata_o, 32'hA5);

        // Wrap: pointer now 3, requests 0 and 1
        set_req(0, 1'b1, 3'd1, 8'h11);
        set_req(1, 1'b1, 3'd2, 8'h22);
        @(negedge clk);
        chk("wrap_gnt0",  bus8.gnt_o,   32'h1);
        chk("wrap_wen0",  bus8.wen_o,   32'hFD);
        chk("wrap_data0", bus8.wdata_o, 32'h11);
        set_req(0, 1'b0, 3'd0, 8'h00);
        wait_gnt(cyc);
        chk("wrap_gnt1",  bus8.gnt_o,   32'h2);
        chk("wrap_gap",   cyc,          32'd3);
        chk("wrap_wen1",  bus8.wen_o,   32'hFB);
        chk("wrap_data1", bus8.wdata_o, 32'h22);
        set_req(1, 1'b0, 3'd0, 8'h00);
        repeat (2) @(negedge clk);

        // Reset during WRITE cancels it immediately
        set_req(2, 1'b1, 3'd1, 8'h77);
        @(negedge clk);
        chk("pre_rst_gnt", bus8.gnt_o, 32'h4);
        clrn = 1'b0;
        #1;
        chk("midrst_wen",   bus8.wen_o,   32'hFF);
        chk("midrst_gnt",   bus8.gnt_o,   32'h0);
        chk("midrst_busy",  bus8.busy_o,  32'h0);
        chk("midrst_wdata", bus8.wdata_o, 32'h0);
        @(negedge clk);
        set_req(2, 1'b0, 3'd0, 8'h00);
        clrn = 1'b1;

        // Fairness: all four request, each drops after its own grant
        for (int k = 0; k < 4; k++) set_req(k, 1'b1, 3'(k + 1), 8'(8'h10 + k));
        for (int k = 0; k < 4; k++) begin
            wait_gnt(cyc);
            chk($sformatf("fair_gnt%0d", k),   bus8.gnt_o,   32'(4'b0001 << k));
            chk($sformatf("fair_gap%0d", k),   cyc,          (k == 0) ? 32'd1 : 32'd3);
            chk($sformatf("fair_wen%0d", k),   bus8.wen_o,   32'(8'hFF ^ (8'h01 << (k + 1))));
            chk($sformatf("fair_data%0d", k),  bus8.wdata_o, 32'(8'h10 + k));
            set_req(k, 1'b0, 3'd0, 8'h00);
        end
        repeat (2) @(negedge clk);

        // Out-of-range address on the 6-register instance
        bus6.req_i        = 4'b0010;
        bus6.addr_i[5:3]  = 3'd7;
        bus6.data_i[15:8] = 8'hFF;
        @(negedge clk);
        chk("range_gnt",   bus6.gnt_o,   32'h2);
        chk("range_wen",   bus6.wen_o,   32'h3F);
        chk("range_err",   bus6.err_o,   32'h1);
        chk("range_wdata", bus6.wdata_o, 32'hFF);
        bus6.req_i = '0;
        @(negedge clk);
        chk("range_err_pulse", bus6.err_o, 32'h0);
        @(negedge clk);
        // Highest valid address on the same instance
        bus6.req_i        = 4'b0010;
        bus6.addr_i[5:3]  = 3'd5;
        bus6.data_i[15:8] = 8'h5A;
        @(negedge clk);
        chk("edge_gnt", bus6.gnt_o, 32'h2);
        chk("edge_wen", bus6.wen_o, 32'h1F);
        chk("edge_err", bus6.err_o, 32'h0);
        bus6.req_i = '0;

        // Address 0: writable unless register 0 is protected
        set_req(0, 1'b1, 3'd0, 8'h3C);
        @(negedge clk);
        chk("a0_gnt",   bus8.gnt_o,   32'h1);
        chk("a0_wdata", bus8.wdata_o, 32'h3C);
`ifdef REG0_PROTECT_EN
        chk("a0_wen", bus8.wen_o, 32'hFF);
        chk("a0_err", bus8.err_o, 32'h1);
`else
        chk("a0_wen", bus8.wen_o, 32'hFE);
        chk("a0_err", bus8.err_o, 32'h0);
`endif
        set_req(0, 1'b0, 3'd0, 8'h00);
        repeat (3) @(negedge clk);
        chk("end_busy", bus8.busy_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
